axi_lite_mem_slave: RTL
=======================

# axi_lite_mem_slave

AXI4-Lite slave memory that terminates the `s` modport of `axi_if` as the downstream consumer of a master's transactions. It provides `MEM_DEPTH` words of byte-writable storage at `BASE_ADDR` and runs independent write and read engines. It serves as the default target in simulation benches and small register-mapped systems.

## Interface
- `ADDR_WIDTH`, 32, address width; matches `C_AXI_ADDR_WIDTH`.
- `DATA_WIDTH`, 32, data width; must be 32 or 64.
- `MEM_DEPTH`, 256, number of data words; must be a power of 2.
- `BASE_ADDR`, 0, byte address of word 0; aligned to `MEM_DEPTH*DATA_WIDTH/8`.
- Clocking: one clock; reset is asynchronous and active-low.
- `ACLK` in 1: clock, rising edge.
- `ARESETn` in 1: asynchronous active-low reset.
- `AWADDR` in `ADDR_WIDTH`: write address.
- `AWVALID` in 1, `AWREADY` out 1: write address handshake.
- `WDATA` in `DATA_WIDTH`: write data.
- `WSTRB` in `DATA_WIDTH/8`: byte enables.
- `WVALID` in 1, `WREADY` out 1: write data handshake.
- `BRESP` out 2: write response.
- `BVALID` out 1, `BREADY` in 1: write response handshake.
- `ARADDR` in `ADDR_WIDTH`: read address.
- `ARVALID` in 1, `ARREADY` out 1: read address handshake.
- `RDATA` out `DATA_WIDTH`: read data.
- `RRESP` out 2: read response.
- `RVALID` out 1, `RREADY` in 1: read data handshake.

## Operation
- **Word index:** `(addr - BASE_ADDR) >> log2(DATA_WIDTH/8)`. Low byte-offset bits are ignored.
- **Write engine:** two states, `W_COLLECT` and `W_RESP`.
  - In `W_COLLECT`, AW and W are captured independently into one-entry holding registers.
  - `AWREADY` is high while the AW holding register is empty and the state is `W_COLLECT`. `WREADY` follows the same rule for the W holding register.
  - Once both holding registers are full, including when both are captured in the same cycle, the next rising edge does the following:
    - commits the bytes whose `WSTRB` bit is set;
    - clears both holding registers;
    - sets `BVALID` and enters `W_RESP`.
  - In `W_RESP`, `BVALID` and `BRESP` are held stable until `BREADY`. After the handshake, the engine returns to `W_COLLECT`.
- **Read engine:** two states, `R_IDLE` and `R_DATA`.
  - `ARREADY` is high only in `R_IDLE`.
  - An AR handshake registers the memory word into `RDATA`, sets `RVALID`, and enters `R_DATA`.
  - `RDATA`, `RRESP` and `RVALID` are held stable until `RREADY`. After the handshake, the engine returns to `R_IDLE`.
- **Same-edge read and write:** the engines are independent. If a write commit and a read capture to the same word occur on the same edge, the read returns the old data (read-before-write).
- **Responses:** `BRESP` and `RRESP` are always `2'b00` (OKAY) unless the DECERR option in Configuration applies.
- **Reset:** memory contents are not reset. Reset asserted mid-operation:
  - clears the holding registers and both states;
  - clears `BVALID` and `RVALID`;
  - does not commit a half-collected write.

## Timing
- **Output reset values:**
  - `AWREADY`, `WREADY`, `ARREADY`: 0;
  - `BVALID`, `RVALID`: 0;
  - `BRESP`, `RRESP`: `2'b00`;
  - `RDATA`: 0.
- **Readies after reset:** all three readies are registered and rise on the first `ACLK` edge after `ARESETn` deasserts.
- **Write latency:** if AW and W both handshake in cycle N, `BVALID` is high in cycle N+1 and memory is updated at that same edge.
- **Staggered write:** AW in cycle N and W in cycle N+k gives `BVALID` in cycle N+k+1. `AWREADY` stays low during cycles N+1 to N+k.
- **Write throughput:** after a B handshake in cycle M, `AWREADY` and `WREADY` are high in cycle M+1. With `BREADY` tied high, one write completes every 2 cycles.
- **Read latency:** an AR handshake in cycle N gives `RVALID` in cycle N+1. After an R handshake in cycle M, `ARREADY` is high in cycle M+1. With `RREADY` tied high, one read completes every 2 cycles.
- **Backpressure:** any number of cycles with `BREADY` or `RREADY` low only extends the `W_RESP` or `R_DATA` state. No data is lost.

## Configuration
- **`AXI_LITE_MEM_DECERR_EN` defined:** an address outside `[BASE_ADDR, BASE_ADDR + MEM_DEPTH*DATA_WIDTH/8)` gets a DECERR response.
  - Write: memory is not modified and `BRESP = 2'b11`.
  - Read: `RDATA = 0` and `RRESP = 2'b11`.
  - Handshake timing is unchanged.
- **`AXI_LITE_MEM_DECERR_EN` undefined:** the word index wraps modulo `MEM_DEPTH` and all responses are OKAY.

## Test plan
- **Reset release:** deassert `ARESETn`, then check `AWREADY`, `WREADY` and `ARREADY` are 0 before the first edge and 1 after it. `BVALID` and `RVALID` stay 0.
- **Simultaneous write, then read:** AW and W in the same cycle, `AWADDR=0x8`, `WDATA=0xDEADBEEF`, `WSTRB=0xF`. Expect `BVALID` the next cycle with `BRESP=0`. Then read `0x8`: `RDATA=0xDEADBEEF`, `RVALID` 1 cycle after AR.
- **Staggered partial write:** W precedes AW by 3 cycles, `WDATA=0x11223344`, `WSTRB=0x3`, to a word previously holding `0xDEADBEEF`. Expect `BVALID` 1 cycle after the AW handshake. A subsequent read returns `0xDEAD3344`.
- **Backpressure:** hold `BREADY=0` and `RREADY=0` for 5 cycles. `BVALID`, `RVALID`, `RDATA` and `BRESP` stay stable, and `AWREADY`, `WREADY` and `ARREADY` stay 0. Release both ready signals: the handshakes complete and the readies return 1 cycle later.
- **Out-of-range access:** with `MEM_DEPTH=256`, write `0x400`.
  - With `AXI_LITE_MEM_DECERR_EN`: `BRESP=2'b11`, word 0 is unchanged, and a read of `0x400` returns `RDATA=0`, `RRESP=2'b11`.
  - Without the macro: word 0 is overwritten with OKAY.
- **Reset mid-write:** capture AW, assert `ARESETn` low before W arrives, release, then read the address. Memory is unchanged, `BVALID` is never asserted, and the readies return 1.

Source files
------------

// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave: AXI4-Lite slave backed by MEM_DEPTH words of byte-writable
// storage at BASE_ADDR. Write and read engines are independent two-state FSMs.
// All handshake outputs are registered; memory contents are not reset.
// Optional feature macro: AXI_LITE_MEM_DECERR_EN. When defined, accesses outside
// the window get DECERR (2'b11). Otherwise the word index wraps modulo MEM_DEPTH.
module axi_lite_mem_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [ADDR_WIDTH-1:0]     ARADDR,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP,
    output logic                      RVALID,
    input  logic                      RREADY
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);

    typedef enum logic {W_COLLECT = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    // Word index relative to BASE_ADDR; byte-offset bits dropped, upper bits wrap.
    function automatic logic [IDX_W-1:0] addr_to_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return off[OFF_W +: IDX_W];
    endfunction

`ifdef AXI_LITE_MEM_DECERR_EN
    // True when addr lies in [BASE_ADDR, BASE_ADDR + MEM_DEPTH*STRB_W); below-base wraps high.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return (off[ADDR_WIDTH-1:OFF_W+IDX_W] == {(ADDR_WIDTH-OFF_W-IDX_W){1'b0}});
    endfunction
`endif

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Write engine state
    w_state_t              w_state_q, w_state_d;
    logic                  aw_full_q, aw_full_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                  w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;

    // Commit path (effective AW/W = holding register or same-cycle handshake)
    logic                  commit_s;
    logic [ADDR_WIDTH-1:0] c_addr_s;
    logic [DATA_WIDTH-1:0] c_data_s;
    logic [STRB_W-1:0]     c_strb_s;
    logic                  c_ok_s;

    // Read engine state
    r_state_t              r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  ar_ok_s;

`ifdef AXI_LITE_MEM_DECERR_EN
    assign c_ok_s  = addr_in_range(c_addr_s);
    assign ar_ok_s = addr_in_range(ARADDR);
`else
    assign c_ok_s  = 1'b1;
    assign ar_ok_s = 1'b1;
`endif

    // Write FSM: collect AW and W independently, commit once both are present, then respond.
    always_comb begin
        w_state_d = w_state_q;
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        commit_s  = 1'b0;
        c_addr_s  = aw_full_q ? aw_addr_q : AWADDR;
        c_data_s  = w_full_q ? w_data_q : WDATA;
        c_strb_s  = w_full_q ? w_strb_q : WSTRB;
        case (w_state_q)
            W_COLLECT: begin
                if (AWVALID && awready_q) begin
                    aw_full_d = 1'b1;
                    aw_addr_d = AWADDR;
                end else begin
                    aw_full_d = aw_full_q;
                end
                if (WVALID && wready_q) begin
                    w_full_d = 1'b1;
                    w_data_d = WDATA;
                    w_strb_d = WSTRB;
                end else begin
                    w_full_d = w_full_q;
                end
                if (aw_full_d && w_full_d) begin
                    commit_s  = c_ok_s;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = c_ok_s ? 2'b00 : 2'b11;
                    w_state_d = W_RESP;
                end else begin
                    w_state_d = W_COLLECT;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_COLLECT;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_COLLECT;
                aw_full_d = 1'b0;
                w_full_d  = 1'b0;
                bvalid_d  = 1'b0;
            end
        endcase
        awready_d = (w_state_d == W_COLLECT) && !aw_full_d;
        wready_d  = (w_state_d == W_COLLECT) && !w_full_d;
    end

    // Read FSM: capture memory word on AR handshake, hold until R handshake.
    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ARVALID && arready_q) begin
                    rdata_d   = ar_ok_s ? mem[addr_to_idx(ARADDR)] : {DATA_WIDTH{1'b0}};
                    rresp_d   = ar_ok_s ? 2'b00 : 2'b11;
                    rvalid_d  = 1'b1;
                    r_state_d = R_DATA;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                rvalid_d  = 1'b0;
            end
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    // Control and response registers for both engines.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q <= W_COLLECT;
            aw_full_q <= 1'b0;
            aw_addr_q <= {ADDR_WIDTH{1'b0}};
            w_full_q  <= 1'b0;
            w_data_q  <= {DATA_WIDTH{1'b0}};
            w_strb_q  <= {STRB_W{1'b0}};
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= {DATA_WIDTH{1'b0}};
            rresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Byte-masked commit; the read capture on the same edge sees the old word.
    always_ff @(posedge ACLK) begin
        if (commit_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (c_strb_s[b]) begin
                    mem[addr_to_idx(c_addr_s)][8*b +: 8] <= c_data_s[8*b +: 8];
                end
            end
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

endmodule
